// File: rtl/mod_counter_pkg.sv
// Shared encodings for the modulo/saturating up/down counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_UP   = 2'b10,
    ST_DOWN = 2'b11
  } state_e;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count arithmetic: step clamp, wrap/saturate, load clamp,
// and bound-shrink recovery. flag_o marks a result that wrapped or clamped.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int Width     = 32,
  parameter int StepWidth = 8,
  parameter int Saturate  = 0
) (
  input  mode_e              mode_i,
  input  logic [StepWidth-1:0] step_i,
  input  logic [Width-1:0]   max_i,
  input  logic [Width-1:0]   load_val_i,
  input  logic [Width-1:0]   data_i,
  output logic [Width-1:0]   next_o,
  output logic               flag_o
);

  logic [Width-1:0] step_ext, step_eff;
  logic [Width:0]   max_p1, sum;

  assign step_ext = Width'(step_i);
  assign step_eff = (step_ext > max_i) ? max_i : step_ext;
  // Width+1 bits so max_i = all-ones gives a true 2^Width modulus.
  assign max_p1   = {1'b0, max_i} + (Width+1)'(1);
  assign sum      = {1'b0, data_i} + {1'b0, step_eff};

  always_comb begin
    next_o = data_i;
    flag_o = 1'b0;
    if (mode_i == MODE_LOAD) begin
      next_o = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (data_i > max_i) begin
      next_o = max_i;
      flag_o = 1'b1;
    end else if (mode_i == MODE_UP) begin
      if (sum <= {1'b0, max_i}) begin
        next_o = sum[Width-1:0];
      end else begin
        flag_o = 1'b1;
        next_o = (Saturate != 0) ? max_i : Width'(sum - max_p1);
      end
    end else if (mode_i == MODE_DOWN) begin
      if (step_eff <= data_i) begin
        next_o = data_i - step_eff;
      end else begin
        flag_o = 1'b1;
        next_o = (Saturate != 0) ? '0
                                 : Width'({1'b0, data_i} + max_p1 - {1'b0, step_eff});
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Bounded up/down counter with load, clear, terminal-count pulse and a small
// state machine reporting the last operation class.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int Width     = 32,
  parameter int StepWidth = 8,
  parameter int Saturate  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [1:0]           mode_i,
  input  logic [StepWidth-1:0] step_i,
  input  logic [Width-1:0]     max_i,
  input  logic [Width-1:0]     load_val_i,
  output logic [Width-1:0]     data_o,
  output logic [1:0]           state_o,
  output logic                 tc_o
);

  logic [Width-1:0] data_q, data_d, nxt;
  state_e           state_q, state_d;
  logic             tc_q, tc_d, flag;
  mode_e            mode;

  assign mode = mode_e'(mode_i);

  mod_counter_next #(
    .Width(Width), .StepWidth(StepWidth), .Saturate(Saturate)
  ) u_next (
    .mode_i(mode), .step_i(step_i), .max_i(max_i), .load_val_i(load_val_i),
    .data_i(data_q), .next_o(nxt), .flag_o(flag)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (clr_i) begin
      data_d  = '0;
      state_d = ST_IDLE;
    end else if (!en_i) begin
      state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_HOLD;
    end else begin
      data_d = nxt;
      tc_d   = flag;
      unique case (mode)
        MODE_UP:   state_d = ST_UP;
        MODE_DOWN: state_d = ST_DOWN;
        default:   state_d = ST_HOLD;
      endcase
    end
  end

  assign data_o  = data_q;
  assign state_o = state_q;
  assign tc_o    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus; each
// directed step queues hand-computed results that a negedge monitor checks.
module tb_mod_counter;

  logic       clk_i = 1'b0;
  logic       rst_i, en_i, clr_i;
  logic [1:0] mode_i;
  logic [3:0] step_i;
  logic [7:0] max_i, load_val_i;
  logic [7:0] dw, ds;
  logic [1:0] stw, sts;
  logic       tcw, tcs;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int    sel;
    int    data;
    int    st;
    int    tc;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk_i = ~clk_i;

  mod_counter #(.Width(8), .StepWidth(4), .Saturate(0)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .mode_i(mode_i),
    .step_i(step_i), .max_i(max_i), .load_val_i(load_val_i),
    .data_o(dw), .state_o(stw), .tc_o(tcw)
  );

  mod_counter #(.Width(8), .StepWidth(4), .Saturate(1)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .mode_i(mode_i),
    .step_i(step_i), .max_i(max_i), .load_val_i(load_val_i),
    .data_o(ds), .state_o(sts), .tc_o(tcs)
  );

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0d expected=%0d", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        chk({e.name, "/wrap"}, "data", int'(dw), e.data);
        chk({e.name, "/wrap"}, "state", int'(stw), e.st);
        chk({e.name, "/wrap"}, "tc", int'(tcw), e.tc);
      end else begin
        chk({e.name, "/sat"}, "data", int'(ds), e.data);
        chk({e.name, "/sat"}, "state", int'(sts), e.st);
        chk({e.name, "/sat"}, "tc", int'(tcs), e.tc);
      end
    end
  end

  task automatic op(input logic r, input logic c, input logic en, input logic [1:0] m,
                    input logic [3:0] s, input logic [7:0] mx, input logic [7:0] ld);
    rst_i = r; clr_i = c; en_i = en; mode_i = m;
    step_i = s; max_i = mx; load_val_i = ld;
    @(posedge clk_i);
    #1;
  endtask

  // Expected results for both variants after the edge just taken.
  task automatic expect2(input string nm, input int st, input int wd, input int wtc,
                         input int sd, input int stc);
    exp_t x;
    x.sel = 0; x.data = wd; x.st = st; x.tc = wtc; x.name = nm;
    sb.push_back(x);
    x.sel = 1; x.data = sd; x.tc = stc;
    sb.push_back(x);
  endtask

  localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DOWN = 2'b10, LOAD = 2'b11;

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; en_i = 1'b1; mode_i = UP;
    step_i = 4'd3; max_i = 8'd9; load_val_i = 8'd0;

    op(1, 0, 1, UP, 3, 9, 0);    expect2("rst1", 0, 0, 0, 0, 0);
    op(1, 0, 1, UP, 3, 9, 0);    expect2("rst2", 0, 0, 0, 0, 0);

    op(0, 0, 1, UP, 3, 9, 0);    expect2("wrap1", 2, 3, 0, 3, 0);
    op(0, 0, 1, UP, 3, 9, 0);    expect2("wrap2", 2, 6, 0, 6, 0);
    op(0, 0, 1, UP, 3, 9, 0);    expect2("wrap3", 2, 9, 0, 9, 0);
    op(0, 0, 1, UP, 3, 9, 0);    expect2("wrap4", 2, 2, 1, 9, 1);

    op(0, 0, 1, LOAD, 0, 9, 2);  expect2("load2", 1, 2, 0, 2, 0);
    op(0, 0, 1, DOWN, 3, 9, 0);  expect2("dn1", 3, 9, 1, 0, 1);
    op(0, 0, 1, DOWN, 3, 9, 0);  expect2("dn2", 3, 6, 0, 0, 1);

    op(0, 0, 1, LOAD, 0, 255, 255); expect2("load255", 1, 255, 0, 255, 0);
    op(0, 0, 1, UP, 1, 255, 0);     expect2("full_up", 2, 0, 1, 255, 1);
    op(0, 0, 1, DOWN, 1, 255, 0);   expect2("full_dn", 3, 255, 1, 254, 0);

    op(0, 1, 1, LOAD, 0, 255, 200); expect2("clr_prio", 0, 0, 0, 0, 0);
    op(0, 0, 0, UP, 1, 255, 0);     expect2("idle_stay", 0, 0, 0, 0, 0);
    op(0, 0, 1, LOAD, 0, 100, 200); expect2("load_clamp", 1, 100, 0, 100, 0);

    op(0, 0, 1, LOAD, 0, 255, 50);  expect2("load50", 1, 50, 0, 50, 0);
    op(0, 0, 0, UP, 1, 255, 0);     expect2("en0_hold", 1, 50, 0, 50, 0);
    op(0, 0, 1, UP, 1, 20, 0);      expect2("shrink", 2, 20, 1, 20, 1);
    op(0, 0, 1, UP, 1, 20, 0);      expect2("top_up", 2, 0, 1, 20, 1);
    op(0, 0, 1, HOLD, 1, 20, 0);    expect2("tc_pulse", 1, 0, 0, 20, 0);

    op(0, 0, 1, LOAD, 0, 5, 3);     expect2("load3", 1, 3, 0, 3, 0);
    op(0, 0, 1, UP, 15, 5, 0);      expect2("step_clamp", 2, 2, 1, 5, 1);
    op(0, 0, 1, UP, 0, 5, 0);       expect2("step0", 2, 2, 0, 5, 0);

    op(1, 0, 1, UP, 3, 5, 0);       expect2("rst_mid", 0, 0, 0, 0, 0);
    op(0, 0, 0, UP, 3, 5, 0);       expect2("post_rst", 0, 0, 0, 0, 0);

    repeat (4) @(negedge clk_i);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter Width, default 32: counter and limit width, minimum 2.
REQ-002 The block SHALL have parameter StepWidth, default 8: step input width, at most Width.
REQ-003 The block SHALL have parameter Saturate, default 0: 0 = wrap modulo (max_i+1), 1 = clamp at bounds.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en_i, input, 1 bit: operation enable.
REQ-008 The block SHALL have port clr_i, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port mode_i, input, 2 bits: HOLD=00, UP=01, DOWN=10, LOAD=11.
REQ-010 The block SHALL have port step_i, input, StepWidth bits: increment/decrement amount.
REQ-011 The block SHALL have port max_i, input, Width bits: upper count bound (inclusive).
REQ-012 The block SHALL have port load_val_i, input, Width bits: LOAD value.
REQ-013 The block SHALL have port data_o, output, Width bits: registered count.
REQ-014 The block SHALL have port state_o, output, 2 bits: registered FSM state.
REQ-015 The block SHALL have port tc_o, output, 1 bit: terminal-count pulse, registered.

Function
REQ-016 Input priority SHALL be, highest first: rst_i, clr_i, en_i=0, mode_i.
REQ-017 data_o SHALL update on the same rising edge at which the operation is sampled (1-cycle latency, no pipeline).
REQ-018 clr_i=1 SHALL set data_o=0, state IDLE, tc_o=0.
REQ-019 en_i=0 or mode HOLD SHALL keep data_o unchanged.
REQ-020 Effective step SHALL be step_i zero-extended, clamped to max_i when greater than max_i.
REQ-021 UP: the sum SHALL be computed in Width+1 bits; if sum <= max_i, next = sum; else next = sum-(max_i+1) when Saturate=0, or max_i when Saturate=1.
REQ-022 DOWN: if step <= data, next = data-step; else next = data+(max_i+1)-step (Width+1 bits) when Saturate=0, or 0 when Saturate=1.
REQ-023 LOAD SHALL set next = min(load_val_i, max_i).
REQ-024 If data_q > max_i at an enabled UP/DOWN/HOLD, next SHALL be max_i (bound shrink recovery) and tc SHALL be set.
REQ-025 tc_o SHALL be 1 for exactly the cycle following an UP/DOWN whose result wrapped or clamped (including REQ-024), and 0 otherwise; step 0 never sets tc.
REQ-026 max_i = all-ones SHALL behave as plain modulo-2^Width / full-range saturation, with no lost carry.
REQ-027 FSM states SHALL be IDLE=00, HOLD=01, UP=10, DOWN=11.
REQ-028 Transitions SHALL be: IDLE stays while en_i=0; from any state, en_i=1 with UP→UP, DOWN→DOWN, LOAD/HOLD→HOLD; en_i=0 from non-IDLE→HOLD; clr_i→IDLE.

Reset
REQ-029 rst_i=1 at a rising edge SHALL force data_o=0, state_o=IDLE, tc_o=0, overriding all inputs, including mid-count.
REQ-030 Outputs SHALL be valid from the first edge after rst_i deasserts; no X on any output after reset.

Structure
REQ-031 Package mod_counter_pkg SHALL hold mode_e (2-bit enum), state_e (2-bit enum) and encodings.
REQ-032 Next-value arithmetic (REQ-020..024, wrap/clamp flag) SHALL be a combinational sub-module mod_counter_next; registers and FSM in mod_counter.

Verification (Width=8, StepWidth=4)
REQ-033 Reset: rst_i=1 for 2 cycles with en_i=1, UP -> data_o=0, state_o=00, tc_o=0.
REQ-034 Wrap: max_i=9, step_i=3, UP from 0 for 4 cycles -> data_o 3,6,9,2; tc_o=1 only after the 4th.
REQ-035 Saturate=1: max_i=9, data=2, DOWN step 3 twice -> data_o 0,0; tc_o=1 both cycles.
REQ-036 Full range: max_i=255, data=255, UP step 1 -> data_o=0, tc_o=1; DOWN step 1 -> 255, tc_o=1.
REQ-037 Priority: clr_i=1 with LOAD 200 -> data_o=0, IDLE; then LOAD 200 with max_i=100 -> 100, HOLD, tc_o=0.
REQ-038 Hold/shrink: count to 50, en_i=0 -> 50 held, HOLD; then max_i=20 with UP step 1 -> 20, tc_o=1.
